// File: rtl/sacc.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : sacc                                                        |
// | Purpose  : FP16 sum-and-scale accumulator for average pooling          |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module sacc #(
  parameter int          N     = 169,
  parameter logic [15:0] RECIP = 16'h1E0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pool_valid,
  input  logic [15:0] data,
  input  logic        data_ready,
  output logic        data_valid,
  output logic        acc_ready,
  output logic        pool_ready,
  output logic [15:0] result
);

  localparam int              c_CW    = $clog2(N + 1);
  localparam logic [c_CW-1:0] c_LAST  = c_CW'(N - 1);
  localparam logic [c_CW-1:0] c_ONE   = c_CW'(1);
  localparam logic [1:0]      c_IDLE  = 2'd0;
  localparam logic [1:0]      c_ACC   = 2'd1;
  localparam logic [1:0]      c_SCALE = 2'd2;
  localparam logic [1:0]      c_DONE  = 2'd3;

  // Round-to-nearest-even on an 11-bit normalised mantissa, then saturate or flush.
  function automatic logic [15:0] fp_pack(input logic sgn, input logic signed [7:0] e,
                                          input logic [10:0] m, input logic g, input logic st);
    logic [11:0]       mr;
    logic signed [7:0] er;
    mr = {1'b0, m} + {11'h0, g & (st | m[0])};
    er = e;
    if (mr[11]) begin
      mr = mr >> 1;
      er = e + 8'sd1;
    end
    if (er >= 8'sd31) return {sgn, 5'h1f, 10'h0};
    if (er <= 8'sd0)  return {sgn, 15'h0};
    return {sgn, er[4:0], mr[9:0]};
  endfunction

  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0]       x, y;
    logic [10:0]       mx, my;
    logic [4:0]        d, p;
    logic [24:0]       ax, yb, ay, mask, s;
    logic [23:0]       sn;
    logic              st;
    logic signed [7:0] e;
    if (a[14:10] == 5'h1f) return {a[15], 5'h1f, 10'h0};
    if (b[14:10] == 5'h1f) return {b[15], 5'h1f, 10'h0};
    if (b[14:0] > a[14:0]) begin
      x = b;
      y = a;
    end else begin
      x = a;
      y = b;
    end
    mx   = (x[14:10] == 5'h0) ? 11'h0 : {1'b1, x[9:0]};
    my   = (y[14:10] == 5'h0) ? 11'h0 : {1'b1, y[9:0]};
    d    = x[14:10] - y[14:10];
    yb   = {1'b0, my, 13'h0};
    ax   = {1'b0, mx, 13'h0};
    mask = 25'h0;
    if (d >= 5'd24) begin
      ay = 25'h0;
      st = |my;
    end else begin
      mask = (25'h1 << d) - 25'h1;
      ay   = yb >> d;
      st   = |(yb & mask);
    end
    // Lost alignment bits are charged as a borrow so the truncated difference stays a floor.
    s = (x[15] == y[15]) ? (ax + ay) : (ax - ay - {24'h0, st});
    if (s == 25'h0) return 16'h0000;
    if (s[24]) return fp_pack(x[15], $signed({3'b0, x[14:10]}) + 8'sd1, s[24:14], s[13], (|s[12:0]) | st);
    p = 5'd0;
    for (int i = 0; i < 24; i++) if (s[i]) p = 5'(i);
    sn = s[23:0] << (5'd23 - p);
    e  = $signed({3'b0, x[14:10]}) - $signed({3'b0, 5'd23 - p});
    return fp_pack(x[15], e, sn[23:13], sn[12], (|sn[11:0]) | st);
  endfunction

  function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
    logic              sgn;
    logic [21:0]       p;
    logic signed [7:0] e;
    sgn = a[15] ^ b[15];
    if (a[14:10] == 5'h1f || b[14:10] == 5'h1f) return {sgn, 5'h1f, 10'h0};
    if (a[14:10] == 5'h0 || b[14:10] == 5'h0)   return {sgn, 15'h0};
    p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e = $signed({3'b0, a[14:10]}) + $signed({3'b0, b[14:10]}) - 8'sd15;
    if (p[21]) return fp_pack(sgn, e + 8'sd1, p[21:11], p[10], |p[9:0]);
    return fp_pack(sgn, e, p[20:10], p[9], |p[8:0]);
  endfunction

  logic [1:0]      state_q, state_d;
  logic [15:0]     acc_q, acc_d;
  logic [15:0]     res_q, res_d;
  logic [c_CW-1:0] cnt_q, cnt_d;
  logic [15:0]     w_sum, w_prod;

  assign w_sum  = fp_add(acc_q, data);
  assign w_prod = fp_mul(acc_q, RECIP);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      c_IDLE: if (pool_valid) begin
        state_d = c_ACC;
        acc_d   = 16'h0000;
        cnt_d   = '0;
      end
      c_ACC: if (data_ready) begin
        acc_d = w_sum;
        cnt_d = cnt_q + c_ONE;
        if (cnt_q == c_LAST) state_d = c_SCALE;
      end
      c_SCALE: begin
        res_d   = w_prod;
        state_d = c_DONE;
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= c_IDLE;
      acc_q   <= 16'h0000;
      cnt_q   <= '0;
      res_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign acc_ready  = (state_q == c_IDLE);
  assign data_valid = (state_q == c_ACC);
  assign pool_ready = (state_q == c_DONE);
  assign result     = res_q;

endmodule
`default_nettype wire

// File: tb/tb_sacc.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_sacc                                                     |
// | Purpose  : randomized scoreboard bench for sacc (N=169 and N=4)        |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module tb_sacc;

  typedef struct {
    logic [15:0] res;
    int          cyc;
    bit          near;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b0;
  logic        pv = 1'b0, dr = 1'b0, pv4 = 1'b0, dr4 = 1'b0;
  logic [15:0] dat = 16'h0, dat4 = 16'h0;
  logic        dv, ar, pr, dv4, ar4, pr4;
  logic [15:0] res, res4;

  int          cyc = 0;
  int          checks = 0, failures = 0;
  exp_t        q169[$], q4[$];
  exp_t        m169, m4;
  logic [15:0] v169[169];
  logic [15:0] v4[4];

  sacc u_dut (
    .clk(clk), .rst(rst), .pool_valid(pv), .data(dat), .data_ready(dr),
    .data_valid(dv), .acc_ready(ar), .pool_ready(pr), .result(res)
  );

  sacc #(.N(4), .RECIP(16'h3400)) u_dut4 (
    .clk(clk), .rst(rst), .pool_valid(pv4), .data(dat4), .data_ready(dr4),
    .data_valid(dv4), .acc_ready(ar4), .pool_ready(pr4), .result(res4)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  // Reference arithmetic: exact real values, rounded once to binary16.
  function automatic real f2r(input logic [15:0] h);
    real v;
    int  e;
    if (h[14:10] == 5'h0) return 0.0;
    v = 1.0 + real'(h[9:0]) / 1024.0;
    e = int'(h[14:10]) - 15;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2f(input real v);
    logic s;
    real  a, sc, fr;
    int   e, ip, be;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    sc = a * 1024.0;
    ip = $rtoi(sc);
    fr = sc - real'(ip);
    if (fr > 0.5 || (fr == 0.5 && (ip % 2) == 1)) ip++;
    if (ip == 2048) begin ip = 1024; e++; end
    be = e + 15;
    if (be >= 31) return {s, 5'h1f, 10'h0};
    if (be <= 0)  return {s, 15'h0};
    return {s, 5'(be), 10'(ip - 1024)};
  endfunction

  function automatic logic [15:0] m_add(input logic [15:0] a, input logic [15:0] b);
    real v;
    if (a[14:10] == 5'h1f) return {a[15], 5'h1f, 10'h0};
    if (b[14:10] == 5'h1f) return {b[15], 5'h1f, 10'h0};
    v = f2r(a) + f2r(b);
    if (v == 0.0) return 16'h0000;
    return r2f(v);
  endfunction

  function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
    logic s;
    s = a[15] ^ b[15];
    if (a[14:10] == 5'h1f || b[14:10] == 5'h1f) return {s, 5'h1f, 10'h0};
    if (a[14:10] == 5'h0 || b[14:10] == 5'h0)   return {s, 15'h0};
    return r2f(f2r(a) * f2r(b));
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_near(input string nm, input logic [15:0] act, input logic [15:0] exp);
    int diff;
    checks++;
    diff = (act > exp) ? int'(act - exp) : int'(exp - act);
    if (diff > 1) begin
      failures++;
      $display("FAIL %s: got %h expected %h +/-1 ulp", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && pr) begin
      if (q169.size() == 0) begin
        checks++; failures++;
        $display("FAIL pool_ready169: unexpected pulse at cycle %0d, none expected", cyc);
      end else begin
        m169 = q169.pop_front();
        check("result169", 32'(res), 32'(m169.res));
        check("latency169", 32'(cyc), 32'(m169.cyc));
        if (m169.near) check_near("const_one169", res, 16'h3C00);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && pr4) begin
      if (q4.size() == 0) begin
        checks++; failures++;
        $display("FAIL pool_ready4: unexpected pulse at cycle %0d, none expected", cyc);
      end else begin
        m4 = q4.pop_front();
        check("result4", 32'(res4), 32'(m4.res));
        check("latency4", 32'(cyc), 32'(m4.cyc));
      end
    end
  end

  // mode 0: random positive 0.03..0.99, 1: all 1.0, 2: replay previous data
  task automatic run169(input int mode, input int stall_pct, input bit hold,
                        input bit extra, input bit gap_chk);
    logic [15:0] acc;
    exp_t        e;
    int          i, g, ar_cnt;
    for (int k = 0; k < 169; k++) begin
      if (mode == 0) v169[k] = {1'b0, 5'($urandom_range(14, 10)), 10'($urandom)};
      else if (mode == 1) v169[k] = 16'h3C00;
    end
    acc = 16'h0000;
    for (int k = 0; k < 169; k++) acc = m_add(acc, v169[k]);
    e.res  = m_mul(acc, 16'h1E0F);
    e.near = (mode == 1);
    e.cyc  = 0;
    pv = 1'b1;
    i = 0; g = 0; ar_cnt = 0;
    while (i < 169 && g < 3000) begin
      @(negedge clk);
      g++;
      if (!dv && i == 0 && ar) ar_cnt++;
      if (dv && !hold) pv = 1'b0;
      if (dv && $urandom_range(99) >= stall_pct) begin
        dr = 1'b1; dat = v169[i]; i++;
        if (i == 169) begin e.cyc = cyc + 2; q169.push_back(e); end
      end else begin
        dr = 1'b0; dat = 16'($urandom);
      end
    end
    if (i < 169) begin
      checks++; failures++;
      $display("FAIL feed169: only %0d of 169 elements accepted in time", i);
    end
    if (gap_chk) check("b2b_idle_cycles", 32'(ar_cnt), 32'd1);
    if (extra) begin
      repeat (4) begin
        @(negedge clk);
        dr = 1'($urandom); dat = 16'($urandom);
      end
    end
    @(negedge clk);
    dr = 1'b0;
    if (!hold) begin
      g = 0;
      while (q169.size() != 0 && g < 20) begin @(negedge clk); g++; end
      check("drain169", 32'(q169.size()), 32'd0);
    end
  endtask

  task automatic run4();
    logic [15:0] acc;
    exp_t        e;
    int          i, g;
    acc = 16'h0000;
    for (int k = 0; k < 4; k++) acc = m_add(acc, v4[k]);
    e.res = m_mul(acc, 16'h3400); e.near = 1'b0; e.cyc = 0;
    pv4 = 1'b1;
    i = 0; g = 0;
    while (i < 4 && g < 100) begin
      @(negedge clk);
      g++;
      if (dv4) begin
        pv4 = 1'b0; dr4 = 1'b1; dat4 = v4[i]; i++;
        if (i == 4) begin e.cyc = cyc + 2; q4.push_back(e); end
      end else dr4 = 1'b0;
    end
    if (i < 4) begin
      checks++; failures++;
      $display("FAIL feed4: only %0d of 4 elements accepted in time", i);
    end
    @(negedge clk);
    dr4 = 1'b0;
    g = 0;
    while (q4.size() != 0 && g < 20) begin @(negedge clk); g++; end
    check("drain4", 32'(q4.size()), 32'd0);
  endtask

  task automatic reset_mid_acc();
    int g;
    pv = 1'b1; g = 0;
    while (!dv && g < 20) begin @(negedge clk); g++; end
    check("reset_test_acc_entered", 32'(dv), 32'd1);
    pv = 1'b0;
    repeat (50) begin
      dr = 1'b1; dat = {1'b0, 5'($urandom_range(14, 10)), 10'($urandom)};
      @(negedge clk);
    end
    #2 rst = 1'b0;
    #1;
    check("rst_data_valid", 32'(dv), 32'd0);
    check("rst_pool_ready", 32'(pr), 32'd0);
    check("rst_result", 32'(res), 32'd0);
    check("rst_acc_ready", 32'(ar), 32'd1);
    dr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_idle", 32'({ar, dv}), 32'b10);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_acc_ready", 32'(ar), 32'd1);
    check("reset_data_valid", 32'(dv), 32'd0);
    check("reset_pool_ready", 32'(pr), 32'd0);
    check("reset_result", 32'(res), 32'd0);
    check("reset4_state", 32'({ar4, dv4, pr4}), 32'b100);
    check("reset4_result", 32'(res4), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run169(0, 0, 1'b0, 1'b0, 1'b0);
    run169(2, 30, 1'b0, 1'b1, 1'b0);
    run169(1, 0, 1'b0, 1'b0, 1'b0);
    run169(0, 0, 1'b1, 1'b0, 1'b0);
    run169(0, 10, 1'b0, 1'b0, 1'b1);
    reset_mid_acc();
    run169(0, 20, 1'b0, 1'b0, 1'b0);

    v4[0] = 16'h4000; v4[1] = 16'hC000; v4[2] = 16'h3C00; v4[3] = 16'hBC00;
    run4();
    v4[0] = 16'h7A00; v4[1] = 16'h7A00; v4[2] = 16'h0000; v4[3] = 16'h0000;
    run4();
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < 4; k++)
        v4[k] = {1'($urandom), 5'($urandom_range(20, 0)), 10'($urandom)};
      if (r % 3 == 0) v4[2] = v4[1] ^ 16'h8000;
      run4();
    end

    check("q169_empty", 32'(q169.size()), 32'd0);
    check("q4_empty", 32'(q4.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
